// File: rtl/cnn_seq_ctrl.sv
// Frame sequencer for a conv -> pool -> fc -> argmax pipeline, one step strobe per cycle.
// Latency CONV_LEN+POOL_LEN+FC_LEN+10 cycles from first CONV to DONE; stall freezes conv/pool/fc, argmax ignores it.
module cnn_seq_ctrl #(
  parameter int CONV_LEN = 676,
  parameter int POOL_LEN = 169,
  parameter int FC_LEN   = 1352,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 stall,
  output logic                 conv_en,
  output logic                 pool_en,
  output logic                 fc_en,
  output logic [CNT_W-1:0]     addr,
  output logic [3:0]           prob_sel,
  input  logic signed [112:0]  prob_in,
  output logic                 busy,
  output logic                 fc_done,
  output logic [3:0]           result,
  output logic [15:0]          count
);

  typedef enum logic [2:0] {IDLE, CONV, POOL, FC, ARGMAX, DONE} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     addr_nxt;
  logic [3:0]           sel_nxt;
  logic signed [112:0]  best_val, best_val_nxt;
  logic [3:0]           best_idx, best_idx_nxt;
  logic [3:0]           result_nxt;
  logic [15:0]          count_nxt;
  logic                 take_new;
  logic signed [112:0]  cand_val;
  logic [3:0]           cand_idx;

  assign busy    = (state != IDLE);
  assign fc_done = (state == DONE);

  // Strict greater-than keeps the lower index on ties; slot 0 always seeds the search.
  assign take_new = (prob_sel == 4'd0) || (prob_in > best_val);
  assign cand_val = take_new ? prob_in  : best_val;
  assign cand_idx = take_new ? prob_sel : best_idx;

  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr;
    sel_nxt      = prob_sel;
    best_val_nxt = best_val;
    best_idx_nxt = best_idx;
    result_nxt   = result;
    count_nxt    = count;
    conv_en      = 1'b0;
    pool_en      = 1'b0;
    fc_en        = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = CONV;
          addr_nxt  = '0;
        end
      end
      CONV: begin
        conv_en = ~stall;
        if (!stall) begin
          if (addr == CNT_W'(CONV_LEN - 1)) begin
            state_nxt = POOL;
            addr_nxt  = '0;
          end else begin
            addr_nxt = addr + CNT_W'(1);
          end
        end
      end
      POOL: begin
        pool_en = ~stall;
        if (!stall) begin
          if (addr == CNT_W'(POOL_LEN - 1)) begin
            state_nxt = FC;
            addr_nxt  = '0;
          end else begin
            addr_nxt = addr + CNT_W'(1);
          end
        end
      end
      FC: begin
        fc_en = ~stall;
        if (!stall) begin
          if (addr == CNT_W'(FC_LEN - 1)) begin
            state_nxt = ARGMAX;
            addr_nxt  = '0;
            sel_nxt   = 4'd0;
          end else begin
            addr_nxt = addr + CNT_W'(1);
          end
        end
      end
      ARGMAX: begin
        best_val_nxt = cand_val;
        best_idx_nxt = cand_idx;
        // Publish on entry to DONE so result/count are already valid while fc_done is high.
        if (prob_sel == 4'd9) begin
          state_nxt  = DONE;
          sel_nxt    = 4'd0;
          result_nxt = cand_idx;
          count_nxt  = count + 16'd1;
        end else begin
          sel_nxt = prob_sel + 4'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        addr_nxt  = '0;
      end
      default: begin
        state_nxt = IDLE;
        addr_nxt  = '0;
        sel_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      addr     <= '0;
      prob_sel <= 4'd0;
      best_val <= '0;
      best_idx <= 4'd0;
      result   <= 4'd0;
      count    <= 16'd0;
    end else begin
      state    <= state_nxt;
      addr     <= addr_nxt;
      prob_sel <= sel_nxt;
      best_val <= best_val_nxt;
      best_idx <= best_idx_nxt;
      result   <= result_nxt;
      count    <= count_nxt;
    end
  end

endmodule
